// File: rtl/tick_meter_pkg.sv
// Shared types and defaults for the tick period meter: FSM state encoding,
// default sizing and the width rule for the lock match counter.
package tick_meter_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_LOCK_CNT = 4;

    typedef enum logic [1:0] {IDLE, ARM, MEAS} meter_state_t;

    function automatic int match_width(input int lock_cnt);
        return $clog2(lock_cnt + 1);
    endfunction

endpackage

// File: rtl/tick_lock_detector.sv
// Counts consecutive identical measurements, saturating at LOCK_CNT.
// Asserts locked once LOCK_CNT equal measurements have been seen in a row.
module tick_lock_detector
    import tick_meter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LOCK_CNT = DEF_LOCK_CNT,
    localparam int MW      = match_width(LOCK_CNT)
) (
    input  logic             clk50m,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] meas,
    input  logic             meas_stb,
    input  logic             clear,
    output logic             locked,
    output logic [MW-1:0]    match
);

    localparam logic [MW-1:0] MATCH_MAX = MW'(LOCK_CNT);

    logic [MW-1:0]    match_q, match_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             locked_q, locked_d;

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned and no latch is inferred.
        match_d  = match_q;
        last_d   = last_q;
        locked_d = locked_q;
        if (clear) begin
            match_d  = '0;
            locked_d = 1'b0;
        end else if (meas_stb) begin
            last_d = meas;
            if (match_q == '0 || meas != last_q) begin
                match_d = MW'(1);
            end else if (match_q != MATCH_MAX) begin
                match_d = match_q + MW'(1);
            end
            locked_d = (match_d == MATCH_MAX);
        end
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            match_q  <= '0;
            last_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            match_q  <= match_d;
            last_q   <= last_d;
            locked_q <= locked_d;
        end
    end

    assign locked = locked_q;
    assign match  = match_q;

endmodule

// File: rtl/tick_period_meter.sv
// Measures the spacing of single-cycle strobes and reports it as a prescaler
// reload value (interval-1), with lock and missing-strobe timeout indication.
module tick_period_meter
    import tick_meter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LOCK_CNT = DEF_LOCK_CNT
) (
    input  logic             clk50m,
    input  logic             rst_n,
    input  logic             en,
    input  logic             tick_in,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [WIDTH-1:0] IVL_MAX = '1;

    meter_state_t     state_q;
    logic [WIDTH-1:0] ivl_q;
    logic [WIDTH-1:0] period_q;
    logic             period_valid_q;
    logic             timeout_q;

    logic ivl_full;
    logic meas_stb;
    logic lock_clear;
    // The match count is kept for debug visibility; only locked leaves the block.
    logic [match_width(LOCK_CNT)-1:0] lock_match_unused;

    assign ivl_full   = (ivl_q == IVL_MAX);
    assign meas_stb   = en && (state_q == MEAS) && tick_in;
    assign lock_clear = !en || (state_q != MEAS) || (ivl_full && !tick_in);

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            ivl_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            period_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            if (!en) begin
                state_q <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: state_q <= ARM;
                    ARM: begin
                        if (tick_in) begin
                            ivl_q   <= '0;
                            state_q <= MEAS;
                        end
                    end
                    MEAS: begin
                        if (tick_in) begin
                            period_q       <= ivl_q;
                            period_valid_q <= 1'b1;
                            ivl_q          <= '0;
                        end else if (ivl_full) begin
                            // Counter is held at its maximum rather than wrapping.
                            timeout_q <= 1'b1;
                            state_q   <= ARM;
                        end else begin
                            ivl_q <= ivl_q + WIDTH'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    tick_lock_detector #(
        .WIDTH    (WIDTH),
        .LOCK_CNT (LOCK_CNT)
    ) u_lock (
        .clk50m   (clk50m),
        .rst_n    (rst_n),
        .meas     (ivl_q),
        .meas_stb (meas_stb),
        .clear    (lock_clear),
        .locked   (locked),
        .match    (lock_match_unused)
    );

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign timeout      = timeout_q;

endmodule
